// File: rtl/matrix_add_scheduler_if.sv
// Bundle of requester and engine signals shared by matrix_add_scheduler and its environment.
// Handshake: a requester holds req high until it sees its ack bit, gnt is held for the whole
// operation, eng_start is a 1-cycle pulse, and eng_done is only honoured while the scheduler waits.
interface matrix_add_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] ack;
  logic               err;
  logic               eng_start;
  logic               eng_done;
  logic [SEL_W-1:0]   eng_sel;
  logic               busy;
  logic [7:0]         err_count;

  modport master (
    output req, eng_done,
    input  gnt, ack, err, eng_start, eng_sel, busy, err_count
  );

  modport slave (
    input  req, eng_done,
    output gnt, ack, err, eng_start, eng_sel, busy, err_count
  );
endinterface

// File: rtl/matrix_add_scheduler.sv
// Round-robin scheduler sharing one 4x4 matrix-add engine among NUM_REQ requesters,
// with a watchdog on the engine completion and a saturating timeout counter.
module matrix_add_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SEL_W          = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_add_scheduler_if.slave bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  localparam int               TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]    TMAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W:0]   NREQ_W = (SEL_W + 1)'(NUM_REQ);

  state_t             state_q;
  logic [SEL_W-1:0]   last_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               err_q;
  logic               start_q;
  logic               busy_q;
  logic [7:0]         err_count_q;
  logic [TW-1:0]      timer_q;

  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W:0]     cand;

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); the first set req bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (SEL_W + 1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && bus.req[cand[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= SEL_W'(NUM_REQ - 1);
      sel_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
      timer_q     <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_LAUNCH;
            gnt_q   <= NUM_REQ'(1) << win_idx;
            sel_q   <= win_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
          timer_q <= '0;
        end
        S_WAIT: begin
          // A done arriving in the last watchdog cycle still counts as a normal completion.
          if (bus.eng_done) begin
            state_q <= S_DONE;
            ack_q   <= gnt_q;
            last_q  <= sel_q;
          end else if (timer_q == TMAX) begin
            state_q <= S_DONE;
            ack_q   <= gnt_q;
            err_q   <= 1'b1;
            last_q  <= sel_q;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.eng_start = start_q;
  assign bus.eng_sel   = sel_q;
  assign bus.busy      = busy_q;
  assign bus.err_count = err_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_matrix_add_scheduler.sv
// Self-checking bench for matrix_add_scheduler: engine model, requesters and an ack scoreboard
// all advance once per clock inside tick(), sampling on the falling edge.
module tb_matrix_add_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  matrix_add_scheduler_if #(.NUM_REQ(NREQ), .SEL_W(2)) bus ();

  matrix_add_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ack    = 0;
  int n_start  = 0;
  int gnt_cyc  = 0;
  int ack_cyc  = 0;
  int eng_k    = 0;
  int eng_cnt  = 0;
  bit eng_stale = 1'b0;
  logic [NREQ-1:0] drop_mask = '1;
  logic [NREQ-1:0] prev_gnt  = '0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: engine model, scoreboard monitor, requester drop on ack.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (eng_stale) begin
      bus.eng_done = 1'b1;
    end else begin
      bus.eng_done = 1'b0;
      if (bus.eng_start && eng_k > 0) eng_cnt = eng_k + 1;
      else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) bus.eng_done = 1'b1;
      end
    end
    if (bus.eng_start) n_start++;
    check_eq("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
    if (bus.gnt != '0 && prev_gnt == '0) gnt_cyc = cyc;
    prev_gnt = bus.gnt;
    if (bus.ack != '0) begin
      ack_cyc = cyc;
      n_ack++;
      if (exp_q.size() == 0) check_eq("ack_unexpected", 32'({bus.err, bus.ack}), 32'd0);
      else begin
        exp_v = exp_q.pop_front();
        check_eq("ack_err", 32'({bus.err, bus.ack}), 32'(exp_v));
      end
      bus.req = bus.req & ~(bus.ack & drop_mask);
    end
  endtask

  task automatic wait_acks(input int target, input int budget, input string tag);
    int b = 0;
    while (n_ack < target && b < budget) begin
      tick();
      b++;
    end
    check_eq(tag, 32'(n_ack >= target), 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
    int b = 0;
    while (state_dbg != st && b < budget) begin
      tick();
      b++;
    end
    check_eq(tag, 32'(state_dbg), 32'(st));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = '0;
    eng_cnt   = 0;
    eng_stale = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    check_eq({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
    check_eq({tag, "_start"}, 32'(bus.eng_start), 32'd0);
    check_eq({tag, "_sel"}, 32'(bus.eng_sel), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_errcnt"}, 32'(bus.err_count), 32'd0);
  endtask

  initial begin
    int base;
    bus.req      = '0;
    bus.eng_done = 1'b0;

    // reset state
    tick();
    check_all_zero("reset");
    check_eq("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // single requester, done 3 cycles after start
    eng_k = 3;
    drop_mask = '1;
    base = n_start;
    exp_q.push_back({1'b0, 4'b0100});
    bus.req = 4'b0100;
    tick();
    check_eq("single_gnt", 32'(bus.gnt), 32'h4);
    check_eq("single_sel", 32'(bus.eng_sel), 32'd2);
    check_eq("single_start", 32'(bus.eng_start), 32'd1);
    check_eq("single_busy", 32'(bus.busy), 32'd1);
    wait_acks(1, 40, "single_ack_seen");
    check_eq("single_latency", 32'(ack_cyc - gnt_cyc), 32'd5);
    repeat (4) tick();
    check_eq("single_starts", 32'(n_start - base), 32'd1);
    check_eq("single_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("single_req_dropped", 32'(bus.req), 32'd0);

    // all four from reset: order 0,1,2,3
    do_reset();
    base = n_ack;
    for (int i = 0; i < NREQ; i++) exp_q.push_back({1'b0, 4'(1 << i)});
    bus.req = 4'b1111;
    wait_acks(base + 4, 80, "rr4_acks_seen");
    repeat (3) tick();
    check_eq("rr4_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rr4_busy", 32'(bus.busy), 32'd0);

    // fairness: req0 held, req3 raised during req0's WAIT
    do_reset();
    eng_k = 4;
    drop_mask = 4'b1000;
    base = n_ack;
    exp_q.push_back({1'b0, 4'b0001});
    exp_q.push_back({1'b0, 4'b1000});
    exp_q.push_back({1'b0, 4'b0001});
    bus.req = 4'b0001;
    wait_state(2'd2, 10, "fair_wait_state");
    bus.req = 4'b1001;
    wait_acks(base + 3, 60, "fair_acks_seen");
    bus.req = '0;
    drop_mask = '1;
    repeat (4) tick();
    check_eq("fair_queue_empty", 32'(exp_q.size()), 32'd0);

    // timeout: engine never completes
    do_reset();
    eng_k = 0;
    base = n_ack;
    exp_q.push_back({1'b1, 4'b0010});
    bus.req = 4'b0010;
    wait_acks(base + 1, 40, "tmo_ack_seen");
    check_eq("tmo_latency", 32'(ack_cyc - gnt_cyc), 32'(TMO + 1));
    tick();
    check_eq("tmo_errcnt1", 32'(bus.err_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({1'b1, 4'b0010});
      bus.req = 4'b0010;
      wait_acks(n_ack + 1, 40, "tmo_loop_ack");
    end
    tick();
    check_eq("tmo_errcnt_sat", 32'(bus.err_count), 32'd255);

    // done arrives in the last watchdog cycle: completion, not timeout
    eng_k = TMO - 1;
    exp_q.push_back({1'b0, 4'b0010});
    bus.req = 4'b0010;
    wait_acks(n_ack + 1, 40, "edge_ack_seen");
    check_eq("edge_latency", 32'(ack_cyc - gnt_cyc), 32'(TMO + 1));
    tick();
    check_eq("edge_errcnt", 32'(bus.err_count), 32'd255);

    // stale done held high before the request
    do_reset();
    eng_stale = 1'b1;
    repeat (3) tick();
    check_eq("stale_idle_busy", 32'(bus.busy), 32'd0);
    base = n_ack;
    exp_q.push_back({1'b0, 4'b0001});
    bus.req = 4'b0001;
    tick();
    check_eq("stale_launch_state", 32'(state_dbg), 32'd1);
    wait_acks(base + 1, 20, "stale_ack_seen");
    check_eq("stale_latency", 32'(ack_cyc - gnt_cyc), 32'd2);
    repeat (8) tick();
    check_eq("stale_single_ack", 32'(n_ack - base), 32'd1);
    eng_stale = 1'b0;

    // reset mid-WAIT with a nonzero error count
    do_reset();
    eng_k = 0;
    exp_q.push_back({1'b1, 4'b0001});
    bus.req = 4'b0001;
    wait_acks(n_ack + 1, 40, "prerst_ack_seen");
    exp_q.push_back({1'b1, 4'b0100});
    bus.req = 4'b0100;
    wait_state(2'd2, 10, "midrst_wait_state");
    tick();
    check_eq("midrst_errcnt_before", 32'(bus.err_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    check_eq("midrst_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    eng_cnt = 0;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    prev_gnt = '0;
    eng_k = 3;
    exp_q.push_back({1'b0, 4'b0010});
    bus.req = 4'b0010;
    tick();
    check_eq("postrst_gnt", 32'(bus.gnt), 32'h2);
    check_eq("postrst_sel", 32'(bus.eng_sel), 32'd1);
    wait_acks(n_ack + 1, 40, "postrst_ack_seen");
    check_eq("postrst_errcnt", 32'(bus.err_count), 32'd0);
    repeat (3) tick();
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
